polar_encoder: RTL and testbench
================================

POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N, default 32, meaning code length in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter QTF_SIZE, default 8, meaning symbol width in bits (signed two's complement).
REQ-003 SHALL have parameter SYM_MAG, default 127, meaning the symbol magnitude emitted for each code bit.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous abort of the frame in progress.
REQ-007 in_valid_i  input  1  message vector u_i and mask are valid.
REQ-008 in_ready_o  output  1  block can accept a new frame.
REQ-009 u_i  input  N  message vector, natural bit order, bit i = u[i].
REQ-010 frozen_mask_i  input  N  frozen-bit mask; a 1 marks a frozen position.
REQ-011 cw_o  output  N  encoded codeword x, valid while sym_valid_o=1.
REQ-012 sym_valid_o  output  1  sym_o holds a valid symbol.
REQ-013 sym_ready_i  input  1  downstream accepts sym_o.
REQ-014 sym_o  output  QTF_SIZE  bipolar symbol for the current code bit.
REQ-015 sym_last_o  output  1  sym_o carries code bit N-1.

Function
REQ-016 SHALL implement a finite state machine with states IDLE, ENCODE and STREAM; in_ready_o SHALL be 1 only in IDLE.
REQ-017 On an input handshake (IDLE, in_valid_i=1, flush_i=0), the block SHALL load v = u_i & ~frozen_mask_i, set stage counter s=0 and enter ENCODE.
REQ-018 Each cycle in ENCODE SHALL apply one butterfly stage: for every i with bit s of i equal to 0, v[i] <= v[i] ^ v[i+2^s]; all other bits are held.
REQ-019 After the stage with s = log2(N)-1, the block SHALL enter STREAM; the first symbol SHALL be valid exactly log2(N) cycles after the acceptance edge.
REQ-020 The result SHALL equal x = u' * F^(kron log2 N), with F = [[1,0],[1,1]], in natural order with no bit reversal.
REQ-021 In STREAM, cw_o SHALL equal v and SHALL be held stable; outside STREAM, cw_o is don't-care.
REQ-022 In STREAM, sym_o SHALL map code bit v[idx] as follows: 0 gives +SYM_MAG (8'h7F), 1 gives -SYM_MAG (8'h81).
REQ-023 The index idx SHALL start at 0 and increment only when sym_valid_o and sym_ready_i are both 1.
REQ-024 While sym_ready_i=0, sym_o and sym_last_o SHALL be held stable.
REQ-025 sym_last_o SHALL be 1 exactly when sym_valid_o=1 and idx=N-1.
REQ-026 On the handshake of the last symbol, the block SHALL return to IDLE; in_ready_o SHALL be 1 on the next cycle.
REQ-027 There SHALL be no overlap between frames: no frame is accepted in ENCODE or STREAM, and there is no bubble beyond the one IDLE cycle.
REQ-028 flush_i=1 in any state SHALL force IDLE on the next edge and clear s and idx; the frame in progress is discarded with no further symbols.
REQ-029 If flush_i and in_valid_i are both 1 in IDLE, flush SHALL win and no frame SHALL be accepted.
REQ-030 frozen_mask_i and u_i SHALL be sampled only at the acceptance edge; later changes SHALL have no effect on the current frame.

Reset
REQ-031 While rst_ni=0, the block SHALL asynchronously enter IDLE with s=0, idx=0 and v=0.
REQ-032 During reset, in_ready_o SHALL be 0 and sym_valid_o=0, sym_last_o=0, sym_o=0 and cw_o=0.
REQ-033 in_ready_o SHALL rise on the first clock edge after rst_ni deasserts.
REQ-034 Reset asserted mid-ENCODE or mid-STREAM SHALL abort the frame; no partial symbols SHALL appear after reset is released.

Verification (N=8)
REQ-035 Scenario: u=8'h01, mask=8'h00 -> cw_o=8'h01; sym_o sequence 81,7F,7F,7F,7F,7F,7F,7F; first symbol 3 cycles after acceptance.
REQ-036 Scenario: u=8'h08, mask=8'h00 -> cw_o=8'h0F; u=8'h80 -> cw_o=8'hFF; sym_last_o=1 on the 8th symbol only.
REQ-037 Scenario: u=8'hFF, mask=8'h7F -> cw_o=8'hFF (only u[7] survives the mask); mask changed after acceptance -> result unchanged.
REQ-038 Scenario: sym_ready_i toggled randomly -> every symbol appears exactly once, in order, held stable while stalled; a back-to-back frame is accepted on the cycle after the last handshake.
REQ-039 Scenario: flush_i pulsed at the 2nd ENCODE cycle and again at the 4th symbol -> IDLE next cycle, no further sym_valid_o; flush_i with in_valid_i in IDLE -> no accept.
REQ-040 Scenario: rst_ni pulsed low mid-STREAM -> outputs go to 0 immediately, in_ready_o=1 one edge after release, and the next frame encodes correctly.

Source files
------------

// File: rtl/polar_encoder.sv
// Polar encoder: masks the message, runs one butterfly stage per cycle, then
// streams the codeword out as bipolar symbols under a valid/ready handshake.
module polar_encoder #(
   parameter int N        = 32,
   parameter int QTF_SIZE = 8,
   parameter int SYM_MAG  = 127
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [N-1:0]        u_i,
   input  logic [N-1:0]        frozen_mask_i,
   output logic [N-1:0]        cw_o,
   output logic                sym_valid_o,
   input  logic                sym_ready_i,
   output logic [QTF_SIZE-1:0] sym_o,
   output logic                sym_last_o
);

   localparam int LOGN = $clog2(N);
   localparam logic [QTF_SIZE-1:0] SYM_POS = QTF_SIZE'(SYM_MAG);
   localparam logic [QTF_SIZE-1:0] SYM_NEG = QTF_SIZE'(-SYM_MAG);

   typedef enum logic [1:0] {IDLE, ENCODE, STREAM} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_armed;
   logic [N-1:0]    r_v;
   logic [LOGN-1:0] r_s;
   logic [LOGN-1:0] r_idx;

   logic            w_accept;
   logic            w_symFire;
   logic            w_lastIdx;
   logic            w_lastStage;
   logic [N-1:0]    w_lowMask;
   logic [LOGN:0]   w_dist;
   logic [N-1:0]    w_stage;

   assign in_ready_o  = r_armed && (r_state == IDLE);
   assign sym_valid_o = (r_state == STREAM);
   assign w_accept    = in_ready_o && in_valid_i && !flush_i;
   assign w_symFire   = sym_valid_o && sym_ready_i;
   assign w_lastIdx   = (r_idx == LOGN'(N - 1));
   assign w_lastStage = (r_s == LOGN'(LOGN - 1));
   assign cw_o        = r_v;
   assign sym_last_o  = sym_valid_o && w_lastIdx;
   assign sym_o       = !sym_valid_o ? '0 : (r_v[r_idx] ? SYM_NEG : SYM_POS);

   // One stage: positions with bit s clear absorb their partner 2^s above.
   always_comb begin
      w_lowMask = '0;
      for (int i = 0; i < N; i++) begin
         w_lowMask[i] = (((i >> r_s) & 1) == 0);
      end
      w_dist  = {{LOGN{1'b0}}, 1'b1} << r_s;
      w_stage = r_v ^ ((r_v >> w_dist) & w_lowMask);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (flush_i) begin
         w_nextState = IDLE;
      end else begin
         unique case (r_state)
            IDLE:    if (w_accept) w_nextState = ENCODE;
            ENCODE:  if (w_lastStage) w_nextState = STREAM;
            STREAM:  if (w_symFire && w_lastIdx) w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v   <= '0;
         r_s   <= '0;
         r_idx <= '0;
      end else if (flush_i) begin
         r_s   <= '0;
         r_idx <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_v   <= u_i & ~frozen_mask_i;
                  r_s   <= '0;
                  r_idx <= '0;
               end
            end
            ENCODE: begin
               r_v <= w_stage;
               r_s <= r_s + 1'b1;
            end
            STREAM: begin
               if (w_symFire) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_polar_encoder.sv
// Testbench for polar_encoder (N=8): directed and random frames checked
// against a generator-matrix reference model with immediate assertions.
module tb_polar_encoder;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         inValid;
   logic         inReady;
   logic [N-1:0] u;
   logic [N-1:0] frozen;
   logic [N-1:0] cw;
   logic         symValid;
   logic         symReady;
   logic [7:0]   sym;
   logic         symLast;

   int compared   = 0;
   int mismatched = 0;

   polar_encoder #(.N(N), .QTF_SIZE(8), .SYM_MAG(127)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .in_valid_i    (inValid),
      .in_ready_o    (inReady),
      .u_i           (u),
      .frozen_mask_i (frozen),
      .cw_o          (cw),
      .sym_valid_o   (symValid),
      .sym_ready_i   (symReady),
      .sym_o         (sym),
      .sym_last_o    (symLast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x[j] is the XOR of every surviving u[i] whose index i covers j bitwise.
   function automatic logic [N-1:0] polarRef(input logic [N-1:0] msg, input logic [N-1:0] mask);
      logic [N-1:0] m;
      logic [N-1:0] x;
      m = msg & ~mask;
      x = '0;
      for (int j = 0; j < N; j++)
         for (int i = 0; i < N; i++)
            if ((j & ~i) == 0) x[j] = x[j] ^ m[i];
      return x;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts and ends just after a falling edge; ends on the first STREAM cycle.
   task automatic applyStimulus(input logic [N-1:0] msg, input logic [N-1:0] mask, input bit changeLater);
      int waitCycles;
      int lat;
      waitCycles = 0;
      while (!inReady && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("readyBeforeAccept", 64'(inReady), 64'd1);
      u       = msg;
      frozen  = mask;
      inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      if (changeLater) begin
         u      = ~msg;
         frozen = ~mask;
      end
      checkOutput("readyLowInEncode", 64'(inReady), 64'd0);
      lat = 0;
      while (!symValid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("firstSymLatency", 64'(lat), 64'd3);
   endtask

   // Streams the frame out; stopAt >= 0 pulses flush on that symbol index.
   task automatic streamFrame(input logic [N-1:0] expCw, input bit randReady, input int stopAt);
      int k;
      int cycles;
      bit rdy;
      k = 0;
      cycles = 0;
      while (k < N && cycles < 200) begin
         if (k == stopAt) begin
            symReady = 1'b0;
            flush    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            checkOutput("flushValid", 64'(symValid), 64'd0);
            checkOutput("flushReady", 64'(inReady), 64'd1);
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               checkOutput("flushNoSym", 64'(symValid), 64'd0);
            end
            return;
         end
         checkOutput("symValid", 64'(symValid), 64'd1);
         checkOutput("symValue", 64'(sym), expCw[k] ? 64'h81 : 64'h7F);
         checkOutput("symLast", 64'(symLast), (k == N - 1) ? 64'd1 : 64'd0);
         checkOutput("codeword", 64'(cw), 64'(expCw));
         rdy = randReady ? bit'($urandom_range(0, 1)) : 1'b1;
         symReady = rdy;
         @(posedge clk);
         if (rdy) k++;
         @(negedge clk);
         cycles++;
      end
      symReady = 1'b0;
      checkOutput("streamDone", 64'(k), 64'(N));
      checkOutput("readyAfterLast", 64'(inReady), 64'd1);
      checkOutput("validAfterLast", 64'(symValid), 64'd0);
   endtask

   initial begin
      logic [N-1:0] ru;
      logic [N-1:0] rm;
      rst_n    = 1'b0;
      flush    = 1'b0;
      inValid  = 1'b0;
      symReady = 1'b0;
      u        = '0;
      frozen   = '0;

      // Reset state
      #2;
      checkOutput("rstReady", 64'(inReady), 64'd0);
      checkOutput("rstValid", 64'(symValid), 64'd0);
      checkOutput("rstLast", 64'(symLast), 64'd0);
      checkOutput("rstSym", 64'(sym), 64'd0);
      checkOutput("rstCw", 64'(cw), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("readyBeforeEdge", 64'(inReady), 64'd0);
      @(negedge clk);
      checkOutput("readyAfterEdge", 64'(inReady), 64'd1);

      // Directed frames, the last three back-to-back
      applyStimulus(8'h01, 8'h00, 1'b0);
      streamFrame(polarRef(8'h01, 8'h00), 1'b0, -1);
      checkOutput("refSanity01", 64'(polarRef(8'h01, 8'h00)), 64'h01);
      applyStimulus(8'h08, 8'h00, 1'b0);
      streamFrame(8'h0F, 1'b0, -1);
      applyStimulus(8'h80, 8'h00, 1'b0);
      streamFrame(8'hFF, 1'b0, -1);
      applyStimulus(8'hFF, 8'h7F, 1'b1);
      streamFrame(8'hFF, 1'b1, -1);

      // Random frames with random downstream stalls
      for (int f = 0; f < 8; f++) begin
         ru = N'($urandom);
         rm = N'($urandom);
         applyStimulus(ru, rm, 1'b1);
         streamFrame(polarRef(ru, rm), 1'b1, -1);
      end

      // Flush during the second ENCODE cycle
      u       = 8'h5A;
      frozen  = 8'h00;
      inValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      checkOutput("encFlushReady", 64'(inReady), 64'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("encFlushNoSym", 64'(symValid), 64'd0);
      end

      // Flush on the fourth symbol
      applyStimulus(8'h3C, 8'h11, 1'b0);
      streamFrame(polarRef(8'h3C, 8'h11), 1'b0, 3);

      // Flush wins over in_valid in IDLE
      u       = 8'hA5;
      inValid = 1'b1;
      flush   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      flush   = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checkOutput("flushWinsReady", 64'(inReady), 64'd1);
         checkOutput("flushWinsNoSym", 64'(symValid), 64'd0);
         @(negedge clk);
      end

      // Reset in the middle of STREAM
      applyStimulus(8'hC3, 8'h00, 1'b0);
      symReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      symReady = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", 64'(symValid), 64'd0);
      checkOutput("midRstSym", 64'(sym), 64'd0);
      checkOutput("midRstLast", 64'(symLast), 64'd0);
      checkOutput("midRstCw", 64'(cw), 64'd0);
      checkOutput("midRstReady", 64'(inReady), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstReady", 64'(inReady), 64'd1);
      checkOutput("postRstNoSym", 64'(symValid), 64'd0);
      applyStimulus(8'h96, 8'h21, 1'b0);
      streamFrame(polarRef(8'h96, 8'h21), 1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
